// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load/enable/prescale in, count and status out.
interface countdown_timer_if #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
);
  logic                 ld;
  logic [WIDTH-1:0]     v;
  logic                 en;
  logic                 auto_reload;
  logic [PRE_WIDTH-1:0] prescale;
  logic [WIDTH-1:0]     count;
  logic                 busy;
  logic                 done;

  modport master (
    output ld, v, en, auto_reload, prescale,
    input  count, busy, done
  );

  modport slave (
    input  ld, v, en, auto_reload, prescale,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled stepping, one-cycle done pulse and optional auto-reload.
module countdown_timer #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     reload_q, reload_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    if (bus.ld) begin
      count_d  = bus.v;
      reload_d = bus.v;
      pre_d    = '0;
      state_d  = (bus.v != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (bus.en) begin
            // >= so a prescale lowered mid-run steps at once instead of wrapping pre_cnt
            if (pre_q >= bus.prescale) begin
              pre_d = '0;
              if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
                if (count_q == WIDTH'(1)) state_d = DONE;
              end
            end else begin
              pre_d = pre_q + PRE_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (bus.auto_reload && reload_q != '0) begin
            count_d = reload_q;
            pre_d   = '0;
            state_d = RUN;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer: expected {count,busy,done} queued per edge, popped after it.
module tb_countdown_timer;
  localparam int W = 16;
  localparam int P = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W), .PRE_WIDTH(P)) bus();
  countdown_timer #(.WIDTH(W), .PRE_WIDTH(P)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W+1:0] val;   // {count, busy, done}
    string        tag;
    int           k;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic void push(string tag, int k, int c, bit b, bit d);
    exp_t e;
    e.val = {W'(c), b, d};
    e.tag = tag;
    e.k   = k;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.ld = 1'b0; bus.v = '0; bus.en = 1'b1; bus.auto_reload = 1'b1; bus.prescale = '0;
    #2;
    push("reset_async", 0, 0, 0, 0);
    e = sb.pop_front(); checks++;
    if ({bus.count, bus.busy, bus.done} !== e.val) begin
      errors++;
      $display("FAIL %s: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag,
               bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 1) bus.ld = 1'b1;   // load must lose to reset
      bus.v = 16'd5;
      push("reset_hold", k, 0, 0, 0);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
    bus.ld = 1'b0; bus.auto_reload = 1'b0;
    rst = 1'b0;
  endtask

  // Load v with prescale p held; count falls by one every p+1 edges, done after edge v*(p+1).
  task automatic test_run(input int v, input int p, input string tag);
    exp_t e;
    int last;
    last = v * (p + 1);
    bus.prescale = P'(p); bus.en = 1'b1; bus.auto_reload = 1'b0;
    for (int k = 0; k <= last + 2; k++) begin
      bus.ld = (k == 0);
      bus.v  = W'(v);
      push(tag, k, (k <= last) ? v - k / (p + 1) : 0, k < last, k == last);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
  endtask

  // Lowering prescale below the running pre_cnt must step immediately.
  task automatic test_prescale_shrink();
    exp_t e;
    int exp_c [8] = '{2, 2, 2, 2, 1, 1, 0, 0};
    bus.en = 1'b1; bus.auto_reload = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.ld = (k == 0);
      bus.v  = 16'd2;
      bus.prescale = (k < 4) ? 8'd5 : 8'd1;
      push("prescale_shrink", k, exp_c[k], k < 6, k == 6);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic test_auto_reload();
    exp_t e;
    int c;
    bit b, d;
    bus.prescale = '0; bus.en = 1'b1;
    for (int k = 0; k < 14; k++) begin
      bus.ld = (k == 0);
      bus.v  = 16'd2;
      bus.auto_reload = (k < 10);
      if (k == 0)       begin c = 2; b = 1; d = 0; end
      else if (k >= 12) begin c = 0; b = 0; d = 0; end
      else case ((k - 1) % 3)
        0:       begin c = 1; b = 1; d = 0; end
        1:       begin c = 0; b = 0; d = 1; end
        default: begin c = 2; b = 1; d = 0; end
      endcase
      push("auto_reload", k, c, b, d);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic test_enable_freeze();
    exp_t e;
    int exp_c [10] = '{4, 3, 2, 2, 2, 2, 2, 1, 0, 0};
    bus.prescale = '0; bus.auto_reload = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.ld = (k == 0);
      bus.v  = 16'd4;
      bus.en = !(k >= 3 && k <= 6);
      push("en_freeze", k, exp_c[k], k < 8, k == 8);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bus.prescale = '0; bus.en = 1'b1; bus.auto_reload = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.ld = (k == 0);
      bus.v  = 16'd10;
      if (k == 4) begin
        #2 rst = 1'b1;
        #1;
        push("mid_reset_async", k, 0, 0, 0);
      end else begin
        if (k == 6) rst = 1'b0;
        push("mid_reset", k, (k < 4) ? 10 - k : 0, k < 4, 0);
        @(posedge clk); #1;
      end
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
    bus.auto_reload = 1'b0;
  endtask

  // ld v=0 aborts to IDLE; ld during DONE beats the auto-reload and replaces reload_reg.
  task automatic test_load_priority();
    exp_t e;
    int c;
    bit b, d;
    bus.prescale = '0; bus.en = 1'b1; bus.auto_reload = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.ld = (k == 0 || k == 1 || k == 4 || k == 8);
      bus.v  = (k == 0) ? 16'd6 : (k == 1 || k == 4) ? 16'd0 : (k == 8) ? 16'd9 : 16'd3;
      if (k == 4) begin bus.ld = 1'b1; bus.v = 16'd3; end
      if (k == 0)      begin c = 6; b = 1; d = 0; end
      else if (k < 4)  begin c = 0; b = 0; d = 0; end
      else if (k < 8)  begin c = 3 - (k - 4); b = (k < 7); d = (k == 7); end
      else if (k < 18) begin c = 9 - (k - 8); b = (k < 17); d = (k == 17); end
      else             begin c = 9 - (k - 18); b = 1; d = 0; end
      push("load_priority", k, c, b, d);
      @(posedge clk); #1;
      e = sb.pop_front(); checks++;
      if ({bus.count, bus.busy, bus.done} !== e.val) begin
        errors++;
        $display("FAIL %s k=%0d: got count=%0d busy=%0b done=%0b, want %0d/%0b/%0b", e.tag, e.k,
                 bus.count, bus.busy, bus.done, e.val[W+1:2], e.val[1], e.val[0]);
      end
    end
    bus.ld = 1'b0; bus.auto_reload = 1'b0;
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_run(5, 0, "basic_v5_p0");
    test_run(3, 2, "prescale_v3_p2");
    test_prescale_shrink();
    test_auto_reload();
    test_enable_freeze();
    test_mid_reset();
    test_load_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
